subservient_sram_bridge: RTL and testbench

//  Parametrised bridge from subservient's byte-wide SRAM port (separate read and write strobes)
//  to a single-port 1rw OpenRAM macro of DW bits. Removes the SoC-level adapter's two limits:

---
 rtl/subservient_sram_bridge_if.sv | 32 +++
 rtl/subservient_sram_bridge.sv | 196 +++++++++++++++++++
 tb/tb_subservient_sram_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/subservient_sram_bridge_if.sv
// Bus bundle between subservient's byte-wide SRAM port and a 1rw OpenRAM macro.
// master = SoC/macro side, slave = bridge.
interface subservient_sram_bridge_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  localparam int BPW = DW / 8;
  localparam int MAW = AW - $clog2(BPW);

  logic [AW-1:0]  i_waddr;
  logic [7:0]     i_wdata;
  logic           i_wen;
  logic [AW-1:0]  i_raddr;
  logic           i_ren;
  logic [7:0]     o_rdata;
  logic           o_mem_csb;
  logic           o_mem_web;
  logic [BPW-1:0] o_mem_wmask;
  logic [MAW-1:0] o_mem_addr;
  logic [DW-1:0]  o_mem_din;
  logic [DW-1:0]  i_mem_dout;

  modport master (
    output i_waddr, i_wdata, i_wen, i_raddr, i_ren, i_mem_dout,
    input  o_rdata, o_mem_csb, o_mem_web, o_mem_wmask, o_mem_addr, o_mem_din
  );

  modport slave (
    input  i_waddr, i_wdata, i_wen, i_raddr, i_ren, i_mem_dout,
    output o_rdata, o_mem_csb, o_mem_web, o_mem_wmask, o_mem_addr, o_mem_din
  );
endinterface

// File: rtl/subservient_sram_bridge.sv
// Byte-wide SRAM port to DW-bit 1rw macro bridge with a merging, forwarding write buffer.
// Define SRAM_BRIDGE_RDBUF_EN to add a one-word read register in front of the macro.
module subservient_sram_bridge #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  subservient_sram_bridge_if.slave          bus,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   o_wbuf_level,
  output logic                              o_overflow
);
  localparam int BPW = DW / 8;
  localparam int LW  = $clog2(BPW);
  localparam int MAW = AW - LW;
  localparam int LVW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {PORT_IDLE, PORT_READ, PORT_DRAIN} port_e;

  // Entry 0 is the head (oldest); entry wb_cnt-1 is the tail.
  logic [MAW-1:0] wb_addr [WBUF_DEPTH];
  logic [DW-1:0]  wb_data [WBUF_DEPTH];
  logic [BPW-1:0] wb_mask [WBUF_DEPTH];
  logic [LVW-1:0] wb_cnt;
  logic [MAW-1:0] nx_addr [WBUF_DEPTH];
  logic [DW-1:0]  nx_data [WBUF_DEPTH];
  logic [BPW-1:0] nx_mask [WBUF_DEPTH];
  logic [LVW-1:0] nx_cnt, cnt_rem;

  port_e          port_op;
  logic           rd_cached, drain, merge, push, drop, tail_draining;
  logic [MAW-1:0] r_word, w_word, tail_addr;
  logic [LW-1:0]  r_lane, w_lane, lane_q;
  logic [BPW-1:0] lane_mask;
  logic           fwd_hit, fwd_hit_q;
  logic [7:0]     fwd_byte, fwd_byte_q;
  logic [DW-1:0]  src_word;

  assign r_word = bus.i_raddr[AW-1:LW];
  assign r_lane = bus.i_raddr[LW-1:0];
  assign w_word = bus.i_waddr[AW-1:LW];
  assign w_lane = bus.i_waddr[LW-1:0];

`ifdef SRAM_BRIDGE_RDBUF_EN
  logic           rb_valid, rd_pend, cached_q;
  logic [MAW-1:0] rb_addr;
  logic [DW-1:0]  rb_data, rb_data_nx;

  // rb_addr is claimed at issue, so a read to the word in flight already hits.
  assign rd_cached = bus.i_ren && rb_valid && (rb_addr == r_word);
  assign src_word  = cached_q ? rb_data : bus.i_mem_dout;

  always_comb begin
    rb_data_nx = rb_data;
    if (rd_pend) rb_data_nx = bus.i_mem_dout;
    if (drain && rb_valid && (rb_addr == wb_addr[0])) begin
      for (int unsigned b = 0; b < BPW; b++)
        if (wb_mask[0][b]) rb_data_nx[b*8 +: 8] = wb_data[0][b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rb_valid <= 1'b0;
      rb_addr  <= '0;
      rb_data  <= '0;
      rd_pend  <= 1'b0;
      cached_q <= 1'b0;
    end else begin
      rd_pend  <= (port_op == PORT_READ);
      cached_q <= rd_cached;
      rb_data  <= rb_data_nx;
      if (port_op == PORT_READ) begin
        rb_valid <= 1'b1;
        rb_addr  <= r_word;
      end
    end
  end
`else
  assign rd_cached = 1'b0;
  assign src_word  = bus.i_mem_dout;
`endif

  always_comb begin
    if (bus.i_ren && !rd_cached) port_op = PORT_READ;
    else if (wb_cnt != '0)       port_op = PORT_DRAIN;
    else                         port_op = PORT_IDLE;
  end

  always_comb begin
    bus.o_mem_csb   = 1'b1;
    bus.o_mem_web   = 1'b1;
    bus.o_mem_wmask = '0;
    bus.o_mem_addr  = '0;
    bus.o_mem_din   = wb_data[0];
    if (!i_rst) begin
      unique case (port_op)
        PORT_READ: begin
          bus.o_mem_csb  = 1'b0;
          bus.o_mem_addr = r_word;
        end
        PORT_DRAIN: begin
          bus.o_mem_csb   = 1'b0;
          bus.o_mem_web   = 1'b0;
          bus.o_mem_addr  = wb_addr[0];
          bus.o_mem_wmask = wb_mask[0];
        end
        default: ;
      endcase
    end
  end

  // Forward from the youngest buffered entry holding the requested byte.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_byte = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      if ((LVW'(i) < wb_cnt) && (wb_addr[i] == r_word) && wb_mask[i][r_lane]) begin
        fwd_hit  = 1'b1;
        fwd_byte = wb_data[i][r_lane*8 +: 8];
      end
    end
  end

  always_comb begin
    drain         = (port_op == PORT_DRAIN);
    tail_draining = drain && (wb_cnt == LVW'(1));
    cnt_rem       = wb_cnt - LVW'(drain);
    lane_mask     = '0;
    lane_mask[w_lane] = 1'b1;
    tail_addr     = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++)
      if (LVW'(i + 1) == wb_cnt) tail_addr = wb_addr[i];
    merge = bus.i_wen && (wb_cnt != '0) && (tail_addr == w_word) && !tail_draining;
    push  = bus.i_wen && !merge && ((wb_cnt < LVW'(WBUF_DEPTH)) || drain);
    drop  = bus.i_wen && !merge && !push;

    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      nx_addr[i] = wb_addr[i];
      nx_data[i] = wb_data[i];
      nx_mask[i] = wb_mask[i];
    end
    if (drain) begin
      for (int unsigned i = 0; i + 1 < WBUF_DEPTH; i++) begin
        nx_addr[i] = wb_addr[i+1];
        nx_data[i] = wb_data[i+1];
        nx_mask[i] = wb_mask[i+1];
      end
    end
    // Indices below refer to the post-pop ordering.
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      if (merge && (LVW'(i + 1) == cnt_rem)) begin
        nx_mask[i]               = nx_mask[i] | lane_mask;
        nx_data[i][w_lane*8 +: 8] = bus.i_wdata;
      end
      if (push && (LVW'(i) == cnt_rem)) begin
        nx_addr[i] = w_word;
        nx_data[i] = {BPW{bus.i_wdata}};
        nx_mask[i] = lane_mask;
      end
    end
    nx_cnt = cnt_rem + LVW'(push);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_cnt     <= '0;
      o_overflow <= 1'b0;
      lane_q     <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_byte_q <= '0;
      for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr[i] <= '0;
        wb_data[i] <= '0;
        wb_mask[i] <= '0;
      end
    end else begin
      wb_cnt <= nx_cnt;
      for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr[i] <= nx_addr[i];
        wb_data[i] <= nx_data[i];
        wb_mask[i] <= nx_mask[i];
      end
      if (drop) o_overflow <= 1'b1;
      if (bus.i_ren) begin
        lane_q     <= r_lane;
        fwd_hit_q  <= fwd_hit;
        fwd_byte_q <= fwd_byte;
      end
    end
  end

  assign bus.o_rdata   = fwd_hit_q ? fwd_byte_q : src_word[lane_q*8 +: 8];
  assign o_wbuf_level  = wb_cnt;
endmodule

// File: tb/tb_subservient_sram_bridge.sv
// Directed bench for subservient_sram_bridge with a behavioural 1rw macro model.
// Covers both builds; the read-register case depends on SRAM_BRIDGE_RDBUF_EN.
module tb_subservient_sram_bridge;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] level;
  logic       overflow;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [31:0] mem [256];
  logic [7:0]  t2_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  subservient_sram_bridge_if #(.AW(AW), .DW(DW)) sif ();

  subservient_sram_bridge #(.AW(AW), .DW(DW), .WBUF_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (sif),
    .o_wbuf_level (level),
    .o_overflow   (overflow)
  );

  always @(posedge clk) begin
    if (!sif.o_mem_csb) begin
      if (!sif.o_mem_web) begin
        for (int b = 0; b < 4; b++)
          if (sif.o_mem_wmask[b]) mem[sif.o_mem_addr][b*8 +: 8] <= sif.o_mem_din[b*8 +: 8];
      end else begin
        sif.i_mem_dout <= mem[sif.o_mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [9:0] a, input logic [7:0] d);
    sif.i_wen = 1'b1; sif.i_waddr = a; sif.i_wdata = d;
  endtask

  task automatic set_rd(input logic [9:0] a);
    sif.i_ren = 1'b1; sif.i_raddr = a;
  endtask

  task automatic quiet();
    sif.i_wen = 1'b0; sif.i_ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sif.i_wen = 1'b0; sif.i_ren = 1'b0;
    sif.i_waddr = '0; sif.i_wdata = '0; sif.i_raddr = '0;
    #2;
    check("rst_csb", sif.o_mem_csb, 1);
    check("rst_web", sif.o_mem_web, 1);
    check("rst_wmask", sif.o_mem_wmask, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    tick(); tick();
    rst = 1'b0;

    // Reset landing on a drain cycle
    set_wr(10'h080, 8'hEE); tick(); quiet(); #1;
    check("md_csb", sif.o_mem_csb, 0);
    check("md_web", sif.o_mem_web, 0);
    check("md_level", level, 1);
    rst = 1'b1; #1;
    check("md_rst_csb", sif.o_mem_csb, 1);
    check("md_rst_web", sif.o_mem_web, 1);
    check("md_rst_level", level, 0);
    tick(); rst = 1'b0; tick();

    // Consecutive byte writes into one word
    for (int i = 0; i < 4; i++) begin
      set_wr(10'(16 + i), t2_d[i]); tick();
      check("t2_level", level, 1);
    end
    quiet(); #1;
    check("t2_drain_web", sif.o_mem_web, 0);
    check("t2_drain_addr", sif.o_mem_addr, 8'h04);
    check("t2_drain_mask", sif.o_mem_wmask, 4'b1000);
    check("t2_drain_din", sif.o_mem_din, 32'h44444444);
    tick();
    check("t2_empty", level, 0);
    check("t2_mem", mem[4], 32'h44332211);
    for (int i = 0; i < 4; i++) begin
      set_rd(10'(16 + i)); tick();
      check("t2_rd", sif.o_rdata, t2_d[i]);
    end
    quiet(); tick();

    // Forwarding while reads starve the drain
    set_rd(10'h000); set_wr(10'h021, 8'hA5); tick(); sif.i_wen = 1'b0;
    check("t3_level0", level, 1);
    set_rd(10'h021); tick();
    check("t3_fwd0", sif.o_rdata, 8'hA5);
    set_rd(10'h030); #1;
    check("t3_rd_web", sif.o_mem_web, 1);
    tick();
    set_rd(10'h000); tick();
    set_rd(10'h021); tick();
    check("t3_fwd1", sif.o_rdata, 8'hA5);
    check("t3_level1", level, 1);
    quiet(); #1;
    check("t3_drain_web", sif.o_mem_web, 0);
    check("t3_drain_addr", sif.o_mem_addr, 8'h08);
    check("t3_drain_mask", sif.o_mem_wmask, 4'b0010);
    check("t3_drain_din", sif.o_mem_din, 32'hA5A5A5A5);
    tick();
    check("t3_empty", level, 0);
    tick();

    // Overflow with reads held high, then FIFO drain order
    set_rd(10'h000); set_wr(10'h100, 8'h01); tick();
    set_rd(10'h030); set_wr(10'h104, 8'h02); tick();
    check("t4_level2", level, 2);
    set_rd(10'h021); set_wr(10'h108, 8'h03); tick();
    sif.i_wen = 1'b0;
    check("t4_full", level, 2);
    check("t4_ovf", overflow, 1);
    set_rd(10'h000); tick();
    check("t4_ovf_hold", overflow, 1);
    quiet(); #1;
    check("t4_d0_addr", sif.o_mem_addr, 8'h40);
    check("t4_d0_din", sif.o_mem_din, 32'h01010101);
    check("t4_d0_mask", sif.o_mem_wmask, 4'b0001);
    tick();
    check("t4_d1_web", sif.o_mem_web, 0);
    check("t4_d1_addr", sif.o_mem_addr, 8'h41);
    check("t4_d1_din", sif.o_mem_din, 32'h02020202);
    tick();
    check("t4_idle_csb", sif.o_mem_csb, 1);
    check("t4_empty", level, 0);
    check("t4_ovf_end", overflow, 1);

    // Top byte address, lane 3
    set_wr(10'h3FF, 8'h5A); tick(); quiet(); #1;
    check("t5_drain_mask", sif.o_mem_wmask, 4'b1000);
    check("t5_drain_addr", sif.o_mem_addr, 8'hFF);
    tick(); tick();
    set_rd(10'h3FF); #1;
    check("t5_rd_csb", sif.o_mem_csb, 0);
    check("t5_rd_web", sif.o_mem_web, 1);
    tick(); quiet();
    check("t5_rdata", sif.o_rdata, 8'h5A);
    tick();

    // Back-to-back reads of one word with a pending write
    set_wr(10'h040, 8'hC1); tick();
    set_wr(10'h041, 8'hC2); tick();
    quiet(); tick(); tick();
    check("t6_prep_empty", level, 0);
    set_rd(10'h040); set_wr(10'h200, 8'h77); #1;
    check("t6_r0_csb", sif.o_mem_csb, 0);
    check("t6_r0_web", sif.o_mem_web, 1);
    check("t6_r0_addr", sif.o_mem_addr, 8'h10);
    tick(); sif.i_wen = 1'b0;
    set_rd(10'h041); #1;
    check("t6_rdata0", sif.o_rdata, 8'hC1);
    check("t6_r1_csb", sif.o_mem_csb, 0);
`ifdef SRAM_BRIDGE_RDBUF_EN
    check("t6_r1_drain_web", sif.o_mem_web, 0);
    check("t6_r1_drain_addr", sif.o_mem_addr, 8'h80);
    check("t6_r1_drain_mask", sif.o_mem_wmask, 4'b0001);
    tick(); quiet(); #1;
    check("t6_rdata1", sif.o_rdata, 8'hC2);
    check("t6_level", level, 0);
`else
    check("t6_r1_web", sif.o_mem_web, 1);
    check("t6_r1_level", level, 1);
    tick(); quiet(); #1;
    check("t6_rdata1", sif.o_rdata, 8'hC2);
    check("t6_drain_web", sif.o_mem_web, 0);
    check("t6_drain_addr", sif.o_mem_addr, 8'h80);
    tick();
    check("t6_level", level, 0);
`endif
    tick();
    check("t6_mem", mem[8'h80][7:0], 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
